// File: rtl/serial_alu.sv
// serial_alu: bit-serial RV32 R-type ALU running in lock-step with a 99-cycle register-file frame
module serial_alu #(
    parameter logic [6:0] OPCODE_R = 7'b0110011,
    parameter int         WR_START = 66
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ins,
    input  logic       rs1,
    input  logic       rs2,
    output logic       rd,
    output logic       enrd,
    output logic       illegal,
    output logic [6:0] cnt
);
    localparam logic [6:0] WS = 7'(WR_START);
    localparam logic [6:0] WE = 7'(WR_START + 31);
    logic [6:0]  cnt_q;
    logic [31:0] ins_q, a_q, b_q, res;
    logic [3:0]  op_q, op_d;
    logic        ill_q, legal_d, win;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh, idx;
    logic        unused;
    assign f3      = ins_q[14:12];
    assign f7      = ins_q[31:25];
    assign legal_d = ins_q[6:0] == OPCODE_R &&
                     (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    assign op_d    = legal_d ? {f7[5], f3} : 4'd0;
    assign sh      = b_q[4:0];
    assign unused  = ^{ins_q[24:15], ins_q[11:7], f7[6], f7[4:0]};
    // frame counter, serial capture of instruction and operands, decode at cycle 32
    always_ff @(posedge clk) begin
        if (reset || cnt_q == 7'd98) begin
            cnt_q <= 7'd0;
            ins_q <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 4'd0;
            ill_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 7'd1;
            if (cnt_q < 7'd32) ins_q <= {ins, ins_q[31:1]};
            if (cnt_q == 7'd32) begin
                op_q  <= op_d;
                ill_q <= !legal_d;
            end
            if (cnt_q >= 7'd34 && cnt_q <= 7'd65) begin
                a_q <= {rs1, a_q[31:1]};
                b_q <= {rs2, b_q[31:1]};
            end
        end
    end
    // 32-bit result from the completed operand buffers; bit 3 of op selects SUB/SRA
    always_comb begin
        res = 32'd0;
        case (op_q)
            4'b0000: res = a_q + b_q;
            4'b1000: res = a_q - b_q;
            4'b0001: res = a_q << sh;
            4'b0010: res = {31'd0, $signed(a_q) < $signed(b_q)};
            4'b0011: res = {31'd0, a_q < b_q};
            4'b0100: res = a_q ^ b_q;
            4'b0101: res = a_q >> sh;
            4'b1101: res = 32'($signed(a_q) >>> sh);
            4'b0110: res = a_q | b_q;
            4'b0111: res = a_q & b_q;
            default: res = 32'd0;
        endcase
    end
    assign win     = cnt_q >= WS && cnt_q <= WE;
    assign idx     = 5'(cnt_q - WS);
    assign enrd    = win && !ill_q;
    assign rd      = enrd && res[idx];
    assign illegal = ill_q;
    assign cnt     = cnt_q;
endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: OPCODE_R, 7'b0110011, R-type opcode accepted for execution.
REQ-002 Parameter: WR_START, 66, first frame cycle of the rd write window; window spans WR_START..WR_START+31.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: ins  input  1  serial instruction bit, LSB first, bit k presented in frame cycle k (0..31).
REQ-006 Port: rs1  input  1  serial rs1 operand bit, LSB first, bit k valid in frame cycle 34+k.
REQ-007 Port: rs2  input  1  serial rs2 operand bit, same timing as rs1.
REQ-008 Port: rd  output  1  serial result bit, LSB first, bit k driven in frame cycle WR_START+k.
REQ-009 Port: enrd  output  1  register-file write enable, high only during the write window of a legal frame.
REQ-010 Port: illegal  output  1  high from cycle 33 to end of frame when the captured instruction is not a supported R-type op.
REQ-011 Port: cnt  output  7  current frame cycle counter (test visibility).

Function
REQ-012 The block SHALL keep a 7-bit frame counter cnt incrementing by 1 every clock, returning to 0 on the clock at which cnt==98 (frame length 99 cycles, lock-step with the register file).
REQ-013 In cycles 0..31 the block SHALL shift ins into a 32-bit instruction buffer so that after cycle 31 buffer bit k equals the ins bit sampled in cycle k.
REQ-014 At cycle 32 the block SHALL decode opcode [6:0], funct3 [14:12], funct7 [31:25] and register the operation select and illegal flag.
REQ-015 Supported ops: funct7=0x00 with funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND; funct7=0x20 with funct3 000 SUB, 101 SRA.
REQ-016 Any other opcode/funct7/funct3 combination SHALL set illegal and SHALL keep enrd low for that entire frame.
REQ-017 In cycles 34..65 the block SHALL sample rs1 and rs2 into 32-bit operand buffers, bit index cnt-34; samples outside this range SHALL be ignored.
REQ-018 The 32-bit result SHALL be a combinational function of the completed operand buffers and the op select; all arithmetic modulo 2^32.
REQ-019 ADD/SUB: two's-complement; SLT signed compare, SLTU unsigned compare, result 0 or 1 zero-extended.
REQ-020 SLL/SRL/SRA: shift rs1 by rs2[4:0]; rs2[31:5] ignored; SRA replicates rs1[31].
REQ-021 During cycles WR_START..WR_START+31 of a legal frame, enrd SHALL be 1 and rd SHALL equal result[cnt-WR_START]; outside the window enrd=0 and rd=0.
REQ-022 The rd field of the instruction SHALL NOT be special-cased; a write to x0 is emitted like any other.
REQ-023 Cycles 32, 33, 66..98 SHALL not modify the operand buffers; the instruction buffer SHALL be modified only in cycles 0..31.
REQ-024 On the cnt==98 wrap the instruction and operand buffers, op select and illegal SHALL clear to 0.

Reset
REQ-025 When reset is high at a clock edge, cnt, instruction buffer, operand buffers, op select and illegal SHALL become 0, overriding every other update including mid-frame.
REQ-026 After reset, enrd=0, rd=0, illegal=0, cnt=0; the next frame begins with cycle 0 on the first clock after reset deasserts.
REQ-027 Reset asserted inside a write window SHALL drop enrd to 0 in the cycle following the reset edge; no partial-write continuation.

Verification
REQ-028 ADD x3,x1,x0 (ins 0x000081B3), rs1=8, rs2=5 -> enrd high cycles 66..97, rd serializes 0x0000000D.
REQ-029 SUB (0x40000033 with fields), rs1=5, rs2=8 -> rd serializes 0xFFFFFFFD.
REQ-030 SRA, rs1=0x80000000, rs2=0xFFFFFFE4 -> rd serializes 0xF8000000 (shift 4).
REQ-031 SLT then SLTU, rs1=0xFFFFFFFF, rs2=1 -> SLT result 1, SLTU result 0.
REQ-032 Instruction 0x00000013 (I-type opcode) -> illegal=1 from cycle 33, enrd never asserted, cnt still wraps at 98.
REQ-033 Reset pulsed at cnt=40 and at cnt=70 -> cnt=0, enrd=0, buffers 0 next cycle; following full ADD frame produces correct result.
